// File: rtl/camera_capture_scheduler.sv
// camera_capture_scheduler
//   Drives the camera grab handshake for single-shot or continuous capture,
//   ping-pongs two DDR frame buffers, publishes completed frames to a
//   consumer (frame_ready / frame_ack) and supervises grabs with a timeout,
//   a retry counter and a sticky fault state.
//
//   Optional build macro: FRAME_DROP_EN
//     defined   : a frame completing while the consumer still holds the
//                 previous one is discarded and counted on dropped_count.
//     undefined : such a frame waits in PUBLISH_WAIT until the consumer acks.
//
//   Handshakes:
//     camera_grab_enable is held high from ARM until camera_grab_done is
//     seen (or the timeout expires); the block then waits for done to
//     return low before starting another grab.
//     frame_ready stays high with a stable frame_base until a frame_ack
//     pulse is seen while frame_ready=1. An ack overlapping the cycle in
//     which a new frame is published belongs to the previous frame, so the
//     new frame stays held.
module camera_capture_scheduler #(
  parameter logic [19:0] FRAME_BASE_0 = 20'h00000,
  parameter logic [19:0] FRAME_BASE_1 = 20'h12C00,
  parameter logic [31:0] GRAB_TIMEOUT = 32'd5000000,
  parameter logic [1:0]  MAX_RETRIES  = 2'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run_enable,
  input  logic        single_shot,
  input  logic        camera_module_detect,
  input  logic        camera_grab_done,
  output logic        camera_grab_enable,
  output logic [19:0] data_write_offset,
  output logic        frame_ready,
  output logic [19:0] frame_base,
  input  logic        frame_ack,
  output logic [15:0] frame_count,
  output logic [1:0]  retry_count,
  output logic        error_timeout,
`ifdef FRAME_DROP_EN
  output logic [15:0] dropped_count,
`endif
  output logic        busy,
  output logic [2:0]  state_debug
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ARM          = 3'd1,
    S_GRAB         = 3'd2,
    S_RELEASE      = 3'd3,
    S_PUBLISH_WAIT = 3'd4,
    S_PUBLISH      = 3'd5,
    S_FAULT        = 3'd6
  } state_t;

  state_t      r_state;
  logic        r_grab_enable;
  logic [19:0] r_write_offset;
  logic        r_frame_ready;
  logic [19:0] r_frame_base;
  logic [15:0] r_frame_count;
  logic [1:0]  r_retry_count;
  logic        r_error_timeout;
  logic        r_write_sel;
  logic [31:0] r_timer;
  logic        r_pending_shot;
  logic        r_done_ok;
`ifdef FRAME_DROP_EN
  logic [15:0] r_dropped_count;
`endif

  // Consumer still holds the previous frame and has not released it.
  logic w_consumer_busy;
  assign w_consumer_busy = r_frame_ready && !frame_ack;

  // Main controller: state, handshakes, buffer selection and publishing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_grab_enable   <= 1'b0;
      r_write_offset  <= FRAME_BASE_0;
      r_frame_ready   <= 1'b0;
      r_frame_base    <= 20'd0;
      r_frame_count   <= 16'd0;
      r_retry_count   <= 2'd0;
      r_error_timeout <= 1'b0;
      r_write_sel     <= 1'b0;
      r_timer         <= 32'd0;
      r_pending_shot  <= 1'b0;
      r_done_ok       <= 1'b0;
`ifdef FRAME_DROP_EN
      r_dropped_count <= 16'd0;
`endif
    end else begin
      // A single_shot pulse is remembered in every state.
      if (single_shot) r_pending_shot <= 1'b1;

      // Consumer release; ignored in PUBLISH and overridden by a publish below.
      if (frame_ack && r_frame_ready && r_state != S_PUBLISH) r_frame_ready <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (run_enable || r_pending_shot) begin
            if (!camera_module_detect) begin
              r_state         <= S_FAULT;
              r_error_timeout <= 1'b1;
            end else begin
              r_state        <= S_ARM;
              r_pending_shot <= single_shot;
            end
          end
        end

        S_ARM: begin
          r_write_offset <= r_write_sel ? FRAME_BASE_1 : FRAME_BASE_0;
          r_grab_enable  <= 1'b1;
          r_timer        <= 32'd0;
          r_state        <= S_GRAB;
        end

        S_GRAB: begin
          r_timer <= r_timer + 32'd1;
          if (camera_grab_done) begin
            r_state       <= S_RELEASE;
            r_grab_enable <= 1'b0;
            r_done_ok     <= 1'b1;
            r_retry_count <= 2'd0;
          end else if (r_timer == GRAB_TIMEOUT - 32'd1) begin
            r_state       <= S_RELEASE;
            r_grab_enable <= 1'b0;
            r_done_ok     <= 1'b0;
            r_retry_count <= r_retry_count + 2'd1;
          end
        end

        S_RELEASE: begin
          if (!camera_grab_done) begin
            if (r_done_ok) begin
              r_state <= S_PUBLISH_WAIT;
            end else if (r_retry_count == MAX_RETRIES) begin
              r_state         <= S_FAULT;
              r_error_timeout <= 1'b1;
            end else begin
              // Retry into the same buffer; write_sel is untouched.
              r_state        <= S_ARM;
              r_pending_shot <= single_shot;
            end
          end
        end

        S_PUBLISH_WAIT: begin
          if (w_consumer_busy) begin
`ifdef FRAME_DROP_EN
            r_dropped_count <= r_dropped_count + 16'd1;
            if (run_enable) begin
              r_state        <= S_ARM;
              r_pending_shot <= single_shot;
            end else begin
              r_state <= S_IDLE;
            end
`else
            r_state <= S_PUBLISH_WAIT;
`endif
          end else begin
            r_frame_base  <= r_write_offset;
            r_frame_ready <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_write_sel   <= ~r_write_sel;
            r_state       <= S_PUBLISH;
          end
        end

        S_PUBLISH: begin
          if (run_enable || r_pending_shot) begin
            r_state        <= S_ARM;
            r_pending_shot <= single_shot;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_FAULT: begin
          r_grab_enable <= 1'b0;
          if (!run_enable && !r_pending_shot) begin
            r_state         <= S_IDLE;
            r_error_timeout <= 1'b0;
            r_retry_count   <= 2'd0;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_grab_enable <= 1'b0;
        end
      endcase
    end
  end

  assign camera_grab_enable = r_grab_enable;
  assign data_write_offset  = r_write_offset;
  assign frame_ready        = r_frame_ready;
  assign frame_base         = r_frame_base;
  assign frame_count        = r_frame_count;
  assign retry_count        = r_retry_count;
  assign error_timeout      = r_error_timeout;
`ifdef FRAME_DROP_EN
  assign dropped_count      = r_dropped_count;
`endif
  assign busy               = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign state_debug        = r_state;

endmodule

// File: doc/camera_capture_scheduler.md
Name: camera_capture_scheduler

Overview:
- Sequences the camera grab handshake (camera_grab_enable / camera_grab_done) to run single-shot or continuous captures.
- Ping-pongs between two 320x240 DDR frame buffers by driving data_write_offset.
- Publishes each completed frame to a downstream consumer with a ready/ack handshake.
- Supervises grabs with a timeout, retry count and fault state. Sits between the system controller and the camera capture block, all in the clk domain.

Parameters:
- FRAME_BASE_0, 20'h00000, DDR word offset of buffer 0.
- FRAME_BASE_1, 20'h12C00, DDR word offset of buffer 1 (76800).
- GRAB_TIMEOUT, 32'd5000000, clk cycles allowed in GRAB before the grab is abandoned.
- MAX_RETRIES, 2'd3, consecutive timeouts tolerated before FAULT.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- run_enable  in  1  level; continuous capture while high.
- single_shot  in  1  one-cycle pulse; capture exactly one frame.
- camera_module_detect  in  1  camera present flag.
- camera_grab_done  in  1  capture block has finished writing the frame.
- camera_grab_enable  out  1  grab request to the capture block.
- data_write_offset  out  20  base offset for the frame being written.
- frame_ready  out  1  a published frame is held for the consumer.
- frame_base  out  20  base offset of the published frame.
- frame_ack  in  1  one-cycle pulse; consumer releases the published frame.
- frame_count  out  16  frames published, wraps at 65535->0.
- retry_count  out  2  consecutive timeouts in the current attempt.
- error_timeout  out  1  sticky fault flag.
- busy  out  1  high in every state except IDLE and FAULT.
- state_debug  out  3  current state encoding.

Behaviour:
- Reset (reset_n=0 at posedge clk) forces IDLE. All outputs go to 0 except data_write_offset=FRAME_BASE_0. write_sel=0, timer=0, pending_shot=0.
- Reset mid-grab drops camera_grab_enable on the next edge. No frame is published.
- State encoding: IDLE=0, ARM=1, GRAB=2, RELEASE=3, PUBLISH_WAIT=4, PUBLISH=5, FAULT=6.
- single_shot is latched into pending_shot in any state. It is cleared on entry to ARM.
- IDLE:
  - If (run_enable | pending_shot), go to ARM.
  - If that condition holds but camera_module_detect=0, go to FAULT instead and set error_timeout.
- ARM (1 cycle):
  - data_write_offset = write_sel ? FRAME_BASE_1 : FRAME_BASE_0.
  - camera_grab_enable=1, timer=0, go to GRAB.
- GRAB:
  - camera_grab_enable stays 1 and timer increments.
  - camera_grab_done=1: go to RELEASE, done_ok=1, retry_count=0.
  - Otherwise, timer==GRAB_TIMEOUT-1: go to RELEASE, done_ok=0, retry_count+1.
  - If done and timeout hit in the same cycle, done wins.
- RELEASE:
  - camera_grab_enable=0. Wait for camera_grab_done=0; the minimum dwell is 1 cycle.
  - If done_ok, go to PUBLISH_WAIT.
  - Else if retry_count==MAX_RETRIES, go to FAULT (error_timeout=1).
  - Else go to ARM, reusing the same buffer.
- PUBLISH_WAIT: if frame_ready=1 and frame_ack=0, stay. Otherwise go to PUBLISH.
- PUBLISH (1 cycle):
  - frame_base = offset just written, frame_ready=1, frame_count+1, write_sel toggles.
  - Next state is ARM if run_enable=1 or pending_shot=1, else IDLE.
- frame_ack handling:
  - frame_ack with frame_ready=1 clears frame_ready next cycle.
  - frame_ack with frame_ready=0 is ignored.
  - If ack and PUBLISH coincide, the publish wins: frame_ready stays 1 with the new base.
- Buffer rule: the buffer targeted in ARM never equals frame_base while frame_ready=1.
- Dropping run_enable during a grab lets the current frame finish and publish, then the block returns to IDLE.
- FAULT:
  - camera_grab_enable=0.
  - Exit to IDLE when run_enable=0 and pending_shot=0. error_timeout clears on that exit; retry_count clears.
- Latency: single_shot pulse to camera_grab_enable=1 is 3 clk edges (latch, IDLE->ARM, ARM output).

Optional Feature:
- Macro: FRAME_DROP_EN.
- Defined:
  - PUBLISH_WAIT is never stalled. If frame_ready=1 and frame_ack=0 when a grab completes, the frame is discarded: no publish, write_sel unchanged.
  - A 16-bit output dropped_count increments (wrapping), and the block goes to ARM if run_enable, else IDLE.
  - The consumer always receives the freshest non-overlapping frame.
- Undefined: the stall behaviour above applies, and the dropped_count port is absent.

Test Plan:
- Single shot: reset, detect=1, single_shot pulse; model raises done 100 cycles after enable → enable high 3 edges after pulse; offset=0x00000; frame_ready=1, frame_base=0x00000, frame_count=1, returns to IDLE.
- Continuous ping-pong: run_enable=1, ack each frame within 10 cycles, 4 frames → offsets alternate 0x00000, 0x12C00, 0x00000, 0x12C00; frame_count=4.
- Stall without ack: run_enable=1, never ack → second frame waits in PUBLISH_WAIT with frame_base=0x00000; ack → frame_base=0x12C00, third grab targets 0x00000. With FRAME_DROP_EN: frames 2+ are dropped, dropped_count increments, offset stays 0x12C00.
- Timeout/retry: GRAB_TIMEOUT=50, done never asserted → 3 ARM attempts each lasting 50 cycles, then FAULT with error_timeout=1 and busy=0; drop run_enable → IDLE, error cleared.
- Timeout recovery: first grab times out, second completes → retry_count returns to 0, frame published at the same offset 0x00000.
- Edge cases:
  - detect=0 with run_enable=1 → FAULT immediately.
  - frame_ack coincident with PUBLISH → frame_ready stays 1.
  - reset_n=0 during GRAB → enable=0 next edge, frame_count unchanged.
